// File: rtl/fnd_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package fnd_pkg;

  localparam int unsigned FND_DIGITS    = 4;
  localparam logic [7:0]  FND_OFF       = 8'hFF;
  localparam logic [6:0]  FND_SEG_BLANK = 7'h7F;
  localparam logic [3:0]  COM_OFF       = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] FONT_0 = 7'h40;
  localparam logic [6:0] FONT_1 = 7'h79;
  localparam logic [6:0] FONT_2 = 7'h24;
  localparam logic [6:0] FONT_3 = 7'h30;
  localparam logic [6:0] FONT_4 = 7'h19;
  localparam logic [6:0] FONT_5 = 7'h12;
  localparam logic [6:0] FONT_6 = 7'h02;
  localparam logic [6:0] FONT_7 = 7'h78;
  localparam logic [6:0] FONT_8 = 7'h00;
  localparam logic [6:0] FONT_9 = 7'h10;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

endpackage

// File: rtl/fnd_font_dec.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show nothing.
module fnd_font_dec
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = FND_SEG_BLANK;
    case (bcd)
      4'd0: seg = FONT_0;
      4'd1: seg = FONT_1;
      4'd2: seg = FONT_2;
      4'd3: seg = FONT_3;
      4'd4: seg = FONT_4;
      4'd5: seg = FONT_5;
      4'd6: seg = FONT_6;
      4'd7: seg = FONT_7;
      4'd8: seg = FONT_8;
      4'd9: seg = FONT_9;
      default: seg = FND_SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode scan controller with pwm dimming, blanking and blinking.
// Define FND_LZB_EN to enable leading-zero blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1,
  parameter int unsigned BLINK_HALF = 500
) (
  input  logic        clk_1k,
  input  logic        rst,
  input  logic [15:0] bcd_data,
  input  logic [3:0]  pwm,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font
);

  localparam int unsigned SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  scan_state_t   state, state_nxt;
  logic [1:0]    digit_sel, digit_nxt;
  logic [SW-1:0] scan_cnt, scan_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;

  logic [3:0]    blank_eff;
  logic [3:0]    dp_eff;
  logic [3:0]    cur_bcd;
  logic [6:0]    cur_seg;
  logic          vis;
  logic [3:0]    com_nxt;
  logic [7:0]    font_nxt;

`ifdef FND_LZB_EN
  logic [3:0] lzb;

  always_comb begin
    lzb    = '0;
    lzb[3] = (bcd_data[15:12] == 4'd0);
    lzb[2] = lzb[3] & (bcd_data[11:8] == 4'd0);
    lzb[1] = lzb[2] & (bcd_data[7:4]  == 4'd0);
  end

  assign blank_eff = blank_mask | lzb;
  assign dp_eff    = dp_in & ~lzb;
`else
  assign blank_eff = blank_mask;
  assign dp_eff    = dp_in;
`endif

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      digit_sel   <= '0;
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      fnd_com     <= COM_OFF;
      fnd_font    <= FND_OFF;
    end else begin
      state       <= state_nxt;
      digit_sel   <= digit_nxt;
      scan_cnt    <= scan_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      fnd_com     <= com_nxt;
      fnd_font    <= font_nxt;
    end
  end

  // The idle state makes the first edge after reset open the digit0 slot
  // instead of advancing past it.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit_sel;
    scan_nxt  = scan_cnt;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_SCAN;
        digit_nxt = '0;
        scan_nxt  = '0;
      end
      ST_SCAN: begin
        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
          scan_nxt  = '0;
          digit_nxt = digit_sel + 2'd1;
        end else begin
          scan_nxt  = scan_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        digit_nxt = '0;
        scan_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    blink_cnt_nxt   = blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase;
    if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end
  end

  assign cur_bcd = bcd_data[{digit_nxt, 2'b00} +: 4];

  fnd_font_dec u_font_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  always_comb begin
    vis      = pwm[digit_nxt] & ~blank_eff[digit_nxt]
             & ~(blink_mask[digit_nxt] & ~blink_phase);
    com_nxt  = vis ? ~(4'b0001 << digit_nxt) : COM_OFF;
    font_nxt = {~dp_eff[digit_nxt], cur_seg};
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomized self-checking bench for fnd_scan_ctrl against a slot/time-based reference model.
module tb_fnd_scan_ctrl;

  localparam int unsigned SD = 1;
  localparam int unsigned BH = 500;

  logic        clk_1k;
  logic        rst;
  logic [15:0] bcd_data;
  logic [3:0]  pwm;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;

  int n_cmp;
  int n_bad;
  int k;  // clock edges since the last reset release

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk_1k     (clk_1k),
    .rst        (rst),
    .bcd_data   (bcd_data),
    .pwm        (pwm),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .fnd_com    (fnd_com),
    .fnd_font   (fnd_font)
  );

  initial begin
    clk_1k = 1'b0;
    forever #5 clk_1k = ~clk_1k;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v < 10) ? t[v] : 7'h7F;
  endfunction

  function automatic int ref_digit(input int kk);
    return ((kk - 1) / SD) % 4;
  endfunction

  function automatic bit ref_lzb(input int d);
`ifdef FND_LZB_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 4; i++)
      if (bcd_data[i*4 +: 4] != 4'd0) hi = i;
    return d > hi;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_com(input int kk);
    int d;
    bit visible_phase;
    bit on;
    d = ref_digit(kk);
    visible_phase = (((kk - 1) / BH) % 2) == 0;
    on = pwm[d] && !blank_mask[d] && !ref_lzb(d) && !(blink_mask[d] && !visible_phase);
    return on ? ~(4'b0001 << d) : 4'b1111;
  endfunction

  function automatic logic [7:0] ref_font(input int kk);
    int d;
    bit dp_on;
    d = ref_digit(kk);
    dp_on = dp_in[d] && !ref_lzb(d);
    return {~dp_on, ref_seg(bcd_data[d*4 +: 4])};
  endfunction

  task automatic cycle();
    @(posedge clk_1k);
    #1;
    k++;
  endtask

  task automatic release_rst();
    @(negedge clk_1k);
    rst = 1'b0;
    k = 0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bcd_data = '0; pwm = 4'hF; dp_in = '0; blank_mask = '0; blink_mask = '0;
    #12;
    n_cmp++;
    if (fnd_com !== 4'b1111) begin
      n_bad++; $display("FAIL reset_com got %b want 1111", fnd_com);
    end
    n_cmp++;
    if (fnd_font !== 8'hFF) begin
      n_bad++; $display("FAIL reset_font got %h want ff", fnd_font);
    end
    release_rst();
  endtask

  task automatic test_scan();
    logic [3:0] exp;
    pwm = 4'hF; blank_mask = '0; blink_mask = '0; dp_in = '0;
    for (int i = 0; i < 16; i++) begin
      bcd_data = rand_bcd();
      cycle();
      exp = ~(4'b0001 << ((k - 1) % 4));
      n_cmp++;
      if (fnd_com !== exp) begin
        n_bad++; $display("FAIL scan_com k=%0d got %b want %b", k, fnd_com, exp);
      end
      n_cmp++;
      if (fnd_font !== ref_font(k)) begin
        n_bad++; $display("FAIL scan_font k=%0d got %h want %h", k, fnd_font, ref_font(k));
      end
    end
  endtask

  task automatic test_font();
    logic [7:0] fixed [4];
    fixed = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    bcd_data = 16'h1234; dp_in = 4'b0100; pwm = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if (fnd_font !== fixed[ref_digit(k)]) begin
        n_bad++; $display("FAIL font_1234 k=%0d got %h want %h", k, fnd_font, fixed[ref_digit(k)]);
      end
    end
    for (int i = 0; i < 48; i++) begin
      bcd_data = 16'($urandom);
      dp_in = 4'($urandom);
      cycle();
      n_cmp++;
      if (fnd_font !== ref_font(k)) begin
        n_bad++; $display("FAIL font_rand k=%0d got %h want %h", k, fnd_font, ref_font(k));
      end
    end
    dp_in = '0;
  endtask

  task automatic test_pwm();
    pwm = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      bcd_data = rand_bcd();
      cycle();
      n_cmp++;
      if (fnd_com !== 4'b1111) begin
        n_bad++; $display("FAIL pwm_off_com k=%0d got %b want 1111", k, fnd_com);
      end
      n_cmp++;
      if (fnd_font !== ref_font(k)) begin
        n_bad++; $display("FAIL pwm_off_font k=%0d got %h want %h", k, fnd_font, ref_font(k));
      end
    end
    pwm = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_cmp++;
      if (fnd_com !== ref_com(k) || (fnd_com !== 4'b1110 && fnd_com !== 4'b1111)) begin
        n_bad++; $display("FAIL pwm_d0_com k=%0d got %b want %b", k, fnd_com, ref_com(k));
      end
    end
    pwm = 4'hF;
  endtask

  task automatic test_blink();
    int seen_on;
    int seen_off;
    blink_mask = 4'b0001; blank_mask = '0; pwm = 4'hF;
    seen_on = 0; seen_off = 0;
    for (int i = 0; i < 1200; i++) begin
      cycle();
      if (ref_digit(k) == 0) begin
        if (fnd_com == 4'b1110) seen_on++; else seen_off++;
      end
      n_cmp++;
      if (fnd_com !== ref_com(k)) begin
        n_bad++; $display("FAIL blink_com k=%0d got %b want %b", k, fnd_com, ref_com(k));
      end
    end
    n_cmp++;
    if (seen_off == 0 || seen_on == 0) begin
      n_bad++; $display("FAIL blink_both_phases on=%0d off=%0d want both nonzero", seen_on, seen_off);
    end
    blank_mask = 4'b0001;
    for (int i = 0; i < 600; i++) begin
      cycle();
      n_cmp++;
      if (fnd_com !== ref_com(k) || fnd_com === 4'b1110) begin
        n_bad++; $display("FAIL blank_over_blink k=%0d got %b want %b", k, fnd_com, ref_com(k));
      end
    end
    blank_mask = '0; blink_mask = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bcd_data = 16'($urandom);
      pwm = 4'($urandom);
      dp_in = 4'($urandom);
      blank_mask = 4'($urandom);
      blink_mask = 4'($urandom);
      cycle();
      n_cmp++;
      if (fnd_com !== ref_com(k)) begin
        n_bad++; $display("FAIL rand_com k=%0d got %b want %b", k, fnd_com, ref_com(k));
      end
      n_cmp++;
      if (fnd_font !== ref_font(k)) begin
        n_bad++; $display("FAIL rand_font k=%0d got %h want %h", k, fnd_font, ref_font(k));
      end
    end
    pwm = 4'hF; dp_in = '0; blank_mask = '0; blink_mask = '0;
  endtask

`ifdef FND_LZB_EN
  task automatic test_lzb();
    logic [15:0] pats [4];
    pats = '{16'h0007, 16'h0000, 16'h0100, 16'h0030};
    pwm = 4'hF; dp_in = 4'hF;
    for (int p = 0; p < 4; p++) begin
      bcd_data = pats[p];
      for (int i = 0; i < 8; i++) begin
        cycle();
        n_cmp++;
        if (fnd_com !== ref_com(k)) begin
          n_bad++; $display("FAIL lzb_com bcd=%h k=%0d got %b want %b", bcd_data, k, fnd_com, ref_com(k));
        end
        n_cmp++;
        if (fnd_font !== ref_font(k)) begin
          n_bad++; $display("FAIL lzb_font bcd=%h k=%0d got %h want %h", bcd_data, k, fnd_font, ref_font(k));
        end
      end
    end
    dp_in = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int budget;
    pwm = 4'hF; blank_mask = '0; blink_mask = '0; bcd_data = rand_bcd();
    budget = 0;
    cycle();
    while (fnd_com !== 4'b1011 && budget < 16) begin
      cycle();
      budget++;
    end
    n_cmp++;
    if (fnd_com !== 4'b1011) begin
      n_bad++; $display("FAIL reset_mid_find_slot2 got %b want 1011", fnd_com);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (fnd_com !== 4'b1111 || fnd_font !== 8'hFF) begin
      n_bad++; $display("FAIL reset_mid_async com=%b font=%h want 1111/ff", fnd_com, fnd_font);
    end
    @(posedge clk_1k);
    #1;
    n_cmp++;
    if (fnd_com !== 4'b1111 || fnd_font !== 8'hFF) begin
      n_bad++; $display("FAIL reset_mid_held com=%b font=%h want 1111/ff", fnd_com, fnd_font);
    end
    release_rst();
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if (fnd_com !== ref_com(k) || (k == 1 && fnd_com !== 4'b1110)) begin
        n_bad++; $display("FAIL reset_mid_restart k=%0d got %b want %b", k, fnd_com, ref_com(k));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    k = 0;
    test_reset();
    test_scan();
    test_font();
    test_pwm();
    test_blink();
    test_random();
`ifdef FND_LZB_EN
    test_lzb();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
